// File: rtl/inst_fetch_unit_if.sv
// Handshake bundle tying the fetch unit to instruction memory, the redirect
// source in execute, and the downstream decode stage.
interface inst_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word fetches, buffers in-order
// responses in a small queue and hands {inst, pc} pairs to decode.
module inst_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_unit_if.master bus
);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] r_fetch_pc;
  ptr_t        r_q_rd;
  ptr_t        r_q_wr;
  ptr_t        r_rpc_rd;
  ptr_t        r_rpc_wr;
  cnt_t        r_q_cnt;
  cnt_t        r_out_cnt;
  cnt_t        r_disc_cnt;

  logic [31:0] w_q_inst [DEPTH];
  logic [31:0] w_q_pc   [DEPTH];
  logic [31:0] w_rpc    [DEPTH];
  logic [CW:0] w_inflight;
  logic        w_req_valid;
  logic        w_req_fire;
  logic        w_resp;
  logic        w_drop;
  logic        w_enq;
  logic        w_deq;
  logic [31:0] w_resp_pc;
  logic        w_unused_redirect_lsb;

  // Outstanding fetches count against capacity even when they will be discarded,
  // so every response always has a queue slot waiting for it.
  assign w_inflight  = {1'b0, r_q_cnt} + {1'b0, r_out_cnt};
  assign w_req_valid = rst && !bus.redirect && (w_inflight < LIMIT);
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;

  assign w_resp    = bus.imem_resp_valid && (r_out_cnt != '0);
  assign w_drop    = bus.redirect || (r_disc_cnt != '0);
  assign w_enq     = w_resp && !w_drop;
  assign w_deq     = !bus.redirect && (r_q_cnt != '0) && bus.inst_ready;
  assign w_resp_pc = w_rpc[r_rpc_rd];

  assign w_unused_redirect_lsb = ^bus.redirect_pc[1:0];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_inst   <= '0;
        r_pc     <= '0;
        r_req_pc <= '0;
      end else begin
        if (w_enq && (r_q_wr == ptr_t'(gi))) begin
          r_inst <= bus.imem_resp_data;
          r_pc   <= w_resp_pc;
        end
        if (w_req_fire && (r_rpc_wr == ptr_t'(gi))) begin
          r_req_pc <= r_fetch_pc;
        end
      end
    end

    assign w_q_inst[gi] = r_inst;
    assign w_q_pc[gi]   = r_pc;
    assign w_rpc[gi]    = r_req_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_q_rd     <= '0;
      r_q_wr     <= '0;
      r_q_cnt    <= '0;
      r_rpc_rd   <= '0;
      r_rpc_wr   <= '0;
      r_out_cnt  <= '0;
      r_disc_cnt <= '0;
    end else begin
      if (bus.redirect) begin
        r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      end else if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end

      r_out_cnt <= r_out_cnt + cnt_t'(w_req_fire) - cnt_t'(w_resp);
      if (w_req_fire) begin
        r_rpc_wr <= r_rpc_wr + ptr_t'(1);
      end
      if (w_resp) begin
        r_rpc_rd <= r_rpc_rd + ptr_t'(1);
      end

      // Everything still in flight after this cycle belongs to the old stream.
      if (bus.redirect) begin
        r_disc_cnt <= r_out_cnt - cnt_t'(w_resp);
      end else if (w_resp && (r_disc_cnt != '0)) begin
        r_disc_cnt <= r_disc_cnt - cnt_t'(1);
      end

      if (bus.redirect) begin
        r_q_rd  <= '0;
        r_q_wr  <= '0;
        r_q_cnt <= '0;
      end else begin
        if (w_enq) begin
          r_q_wr <= r_q_wr + ptr_t'(1);
        end
        if (w_deq) begin
          r_q_rd <= r_q_rd + ptr_t'(1);
        end
        r_q_cnt <= r_q_cnt + cnt_t'(w_enq) - cnt_t'(w_deq);
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = (r_q_cnt != '0);
  assign bus.inst           = w_q_inst[r_q_rd];
  assign bus.inst_pc        = w_q_pc[r_q_rd];

  a_capacity: assert property (@(posedge clk) disable iff (!rst) w_inflight <= LIMIT);
  a_discard:  assert property (@(posedge clk) disable iff (!rst) r_disc_cnt <= r_out_cnt);
  a_align:    assert property (@(posedge clk) disable iff (!rst) r_fetch_pc[1:0] == 2'b00);
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: in-order memory model with variable latency, an
// architectural expected-stream scoreboard, directed scenarios and a random soak.
module tb_inst_fetch_unit;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_unit_if bus_if();

  inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] req_log[$];
  logic [31:0] run_next_pc = RESET_PC;
  int          cyc = 0;
  int          mem_lat = 1;
  int          req_ready_pct = 100;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_deliv = 0;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, want);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] want);
    check(act === want, name, act, want);
  endtask

  task automatic sb_fill();
    while (exp_q.size() < 64) begin
      exp_q.push_back('{pc: run_next_pc, word: mem_word(run_next_pc)});
      run_next_pc = run_next_pc + 32'd4;
    end
  endtask

  // A new architectural stream starts at reset release or at a redirect target.
  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    run_next_pc = {pc[31:2], 2'b00};
    sb_fill();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    sb_fill();
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b0;
    bus_if.redirect   = 1'b0;
    bus_if.inst_ready = ready;
    tick();
    tick();
    rst = 1'b1;
    req_log.delete();
    sb_restart(RESET_PC);
  endtask

  // Memory response side: in order, one word per cycle, at least mem_lat after acceptance.
  initial begin
    bus_if.imem_req_ready  = 1'b0;
    bus_if.imem_resp_valid = 1'b0;
    bus_if.imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        pend_q.delete();
        bus_if.imem_resp_valid = 1'b0;
        bus_if.imem_resp_data  = '0;
      end else begin
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
          bus_if.imem_resp_valid = 1'b1;
          bus_if.imem_resp_data  = mem_word(pend_q[0].addr);
          void'(pend_q.pop_front());
        end else begin
          bus_if.imem_resp_valid = 1'b0;
          bus_if.imem_resp_data  = '0;
        end
      end
      bus_if.imem_req_ready = ($urandom_range(99) < req_ready_pct);
    end
  end

  // Memory request side: records every accepted fetch.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus_if.imem_req_valid && bus_if.imem_req_ready) begin
        check_eq("req_align", {30'b0, bus_if.imem_req_addr[1:0]}, 32'd0);
        pend_q.push_back('{addr: bus_if.imem_req_addr, due: cyc + mem_lat});
        req_log.push_back(bus_if.imem_req_addr);
        $display("[%0t] req  addr=%h", $time, bus_if.imem_req_addr);
      end
    end
  end

  // Delivery monitor: every consumed instruction must be the next one of the stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus_if.inst_valid && bus_if.inst_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "sb_underflow", bus_if.inst_pc, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("inst_pc", bus_if.inst_pc, e.pc);
          check_eq("inst", bus_if.inst, e.word);
          n_deliv++;
          $display("[%0t] inst pc=%h word=%h", $time, bus_if.inst_pc, bus_if.inst);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got %0d, expected finish", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          found;
    int          streak;
    int          deliv0;
    logic [31:0] tgt;

    bus_if.redirect    = 1'b0;
    bus_if.redirect_pc = '0;
    bus_if.inst_ready  = 1'b1;
    #1 rst = 1'b0;

    // Reset state
    tick();
    check_eq("rst_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
    check_eq("rst_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    check_eq("rst_inst", bus_if.inst, 32'd0);
    check_eq("rst_inst_pc", bus_if.inst_pc, 32'd0);

    // Streaming with 1-cycle memory and decode always ready
    tick();
    rst = 1'b1;
    req_log.delete();
    sb_restart(RESET_PC);
    @(negedge clk);
    check_eq("first_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd1);
    check_eq("first_req_addr", bus_if.imem_req_addr, RESET_PC);
    @(negedge clk);
    check_eq("startup_c1_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    @(negedge clk);
    check_eq("startup_c2_valid", {31'b0, bus_if.inst_valid}, 32'd1);
    check_eq("startup_c2_pc", bus_if.inst_pc, RESET_PC);
    streak = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.inst_valid) streak++;
    end
    check_eq("throughput", 32'(streak), 32'd20);

    // Decode stalled: exactly DEPTH fetches, then the request side waits for a pop
    do_reset(1'b0);
    repeat (12) tick();
    check_eq("stall_req_count", 32'(req_log.size()), 32'(DEPTH));
    for (int i = 0; i < 4; i++) begin
      if (i < req_log.size()) check_eq("stall_req_addr", req_log[i], RESET_PC + 32'(4 * i));
      else check(1'b0, "stall_req_addr", 32'd0, RESET_PC + 32'(4 * i));
    end
    @(negedge clk);
    check_eq("stall_inst_valid", {31'b0, bus_if.inst_valid}, 32'd1);
    check_eq("stall_inst_pc", bus_if.inst_pc, RESET_PC);
    check_eq("stall_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
    tick();
    bus_if.inst_ready = 1'b1;
    tick();
    bus_if.inst_ready = 1'b0;
    @(negedge clk);
    check_eq("resume_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd1);
    check_eq("resume_req_addr", bus_if.imem_req_addr, RESET_PC + 32'h10);

    // 3-cycle memory, redirect with two fetches in flight
    mem_lat = 3;
    do_reset(1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (req_log.size() >= 2) found = 1'b1;
    end
    check_eq("redir_inflight", 32'(req_log.size()), 32'd2);
    bus_if.redirect    = 1'b1;
    bus_if.redirect_pc = 32'h0000_0103;
    @(negedge clk);
    check_eq("redir_cycle_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
    tick();
    bus_if.redirect = 1'b0;
    sb_restart(32'h0000_0103);
    @(negedge clk);
    check_eq("redir_flush_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    check_eq("redir_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd1);
    check_eq("redir_req_addr", bus_if.imem_req_addr, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus_if.inst_valid) found = 1'b1;
    end
    check_eq("redir_first_pc", found ? bus_if.inst_pc : 32'hDEAD_DEAD, 32'h0000_0100);
    repeat (30) tick();

    // Redirect in the same cycle as a response and a pop
    mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (bus_if.imem_resp_valid && bus_if.inst_valid) found = 1'b1;
    end
    check_eq("coincide_found", {31'b0, found}, 32'd1);
    bus_if.redirect    = 1'b1;
    bus_if.redirect_pc = 32'h0000_2000;
    bus_if.inst_ready  = 1'b1;
    tick();
    bus_if.redirect = 1'b0;
    sb_restart(32'h0000_2000);
    @(negedge clk);
    check_eq("coincide_flush", {31'b0, bus_if.inst_valid}, 32'd0);
    repeat (20) tick();

    // Address wrap at the top of memory
    bus_if.redirect    = 1'b1;
    bus_if.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus_if.redirect = 1'b0;
    sb_restart(32'hFFFF_FFFC);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus_if.inst_valid) found = 1'b1;
    end
    check_eq("wrap_first_pc", found ? bus_if.inst_pc : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
    @(negedge clk);
    check_eq("wrap_second_pc", bus_if.inst_pc, 32'h0000_0000);
    repeat (10) tick();

    // Asynchronous reset with three instructions queued
    do_reset(1'b0);
    repeat (4) tick();
    check_eq("prereset_valid", {31'b0, bus_if.inst_valid}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check_eq("async_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
    check_eq("async_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    check_eq("async_inst", bus_if.inst, 32'd0);
    check_eq("async_inst_pc", bus_if.inst_pc, 32'd0);
    do_reset(1'b1);
    @(negedge clk);
    check_eq("restart_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd1);
    check_eq("restart_req_addr", bus_if.imem_req_addr, RESET_PC);
    repeat (10) tick();

    // Random soak: latency, backpressure and redirects all vary
    req_ready_pct = 70;
    deliv0 = n_deliv;
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) mem_lat = $urandom_range(4, 1);
      bus_if.inst_ready = ($urandom_range(99) < 70);
      if ($urandom_range(29) == 0) begin
        case ($urandom_range(2))
          0:       tgt = $urandom;
          1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
          default: tgt = {16'h0, 16'($urandom_range(65535))};
        endcase
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = tgt;
        tick();
        bus_if.redirect = 1'b0;
        sb_restart(tgt);
      end else begin
        tick();
      end
    end
    check(n_deliv - deliv0 > 100, "random_progress", 32'(n_deliv - deliv0), 32'd101);

    bus_if.inst_ready = 1'b1;
    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
